// File: rtl/sprite_queue_pkg.sv
// Shared sprite draw-queue record format, used by both the queue producer and sprite_driver.
package sprite_queue_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } sprite_entry_t;

    localparam int SPRITE_REC_BYTES = 6;
    localparam int SPRITE_REC_BITS  = $bits(sprite_entry_t);

endpackage

// File: rtl/sprite_queue_fifo.sv
// Generic first-word-fall-through FIFO; read data valid while !o_empty, write lands after one edge.
// Pushes are dropped when full, pops are ignored when empty, and flush has priority over both.
module sprite_queue_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rd_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_reset) r_mem[r_wr_ptr] <= i_wr_dat;
    end

endmodule

// File: rtl/sprite_queue.sv
// Assembles 6-byte sprite commands into records and queues them FWFT; head valid one edge after the last byte.
// in_ready drops only when the sixth byte is pending and the queue is full; it never depends on dequeue.
module sprite_queue
    import sprite_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    input  logic [7:0]               i_in_data,
    output logic                     o_in_ready,
    input  logic                     i_flush,
    input  logic                     i_sprite_queue_dequeue,
    output logic                     o_sprite_queue_is_empty,
    output logic [7:0]               o_sprite_queue_sprite_id,
    output logic [15:0]              o_sprite_queue_sprite_x,
    output logic [15:0]              o_sprite_queue_sprite_y,
    output logic [7:0]               o_sprite_queue_sprite_scale,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam logic [2:0] LAST_IDX = 3'(SPRITE_REC_BYTES - 1);

    logic [2:0]                 r_byte_idx;
    logic [39:0]                r_shift;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_full;
    sprite_entry_t              w_wr_entry;
    sprite_entry_t              w_head;
    logic [SPRITE_REC_BITS-1:0] w_rd_dat;

    assign o_in_ready = !(r_byte_idx == LAST_IDX && w_full);
    assign w_accept   = i_in_valid && o_in_ready && !i_flush;
    assign w_push     = w_accept && (r_byte_idx == LAST_IDX);
    // Earlier bytes sit MSB-first in the shift register, matching the packed record order.
    assign w_wr_entry = sprite_entry_t'({r_shift, i_in_data});

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_byte_idx <= '0;
        end else if (w_accept) begin
            if (r_byte_idx == LAST_IDX) begin
                r_byte_idx <= '0;
            end else begin
                r_byte_idx <= r_byte_idx + 3'd1;
                r_shift    <= {r_shift[31:0], i_in_data};
            end
        end
    end

    sprite_queue_fifo #(
        .WIDTH (SPRITE_REC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push   (w_push),
        .i_wr_dat (w_wr_entry),
        .i_pop    (i_sprite_queue_dequeue),
        .i_flush  (i_flush),
        .o_rd_dat (w_rd_dat),
        .o_full   (w_full),
        .o_empty  (o_sprite_queue_is_empty),
        .o_count  (o_count)
    );

    assign w_head                      = sprite_entry_t'(w_rd_dat);
    assign o_sprite_queue_sprite_id    = w_head.id;
    assign o_sprite_queue_sprite_x     = w_head.x;
    assign o_sprite_queue_sprite_y     = w_head.y;
    assign o_sprite_queue_sprite_scale = w_head.scale;

endmodule

// File: tb/tb_sprite_queue.sv
// Self-checking bench for sprite_queue: vector table, scoreboard and multi-cycle corner sequences.
module tb_sprite_queue;
    import sprite_queue_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = 8'h00;
    logic        o_in_ready;
    logic        i_flush = 1'b0;
    logic        i_dequeue = 1'b0;
    logic        o_is_empty;
    logic [7:0]  o_id;
    logic [15:0] o_x;
    logic [15:0] o_y;
    logic [7:0]  o_scale;
    logic [4:0]  o_count;

    int n_tests = 0;
    int n_fail  = 0;
    sprite_entry_t exp_q[$];

    typedef struct {
        logic [47:0] bytes;
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } vec_t;

    sprite_queue #(.DEPTH(16)) dut (
        .i_clk                       (clk),
        .i_reset                     (i_reset),
        .i_in_valid                  (i_in_valid),
        .i_in_data                   (i_in_data),
        .o_in_ready                  (o_in_ready),
        .i_flush                     (i_flush),
        .i_sprite_queue_dequeue      (i_dequeue),
        .o_sprite_queue_is_empty     (o_is_empty),
        .o_sprite_queue_sprite_id    (o_id),
        .o_sprite_queue_sprite_x     (o_x),
        .o_sprite_queue_sprite_y     (o_y),
        .o_sprite_queue_sprite_scale (o_scale),
        .o_count                     (o_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] head();
        return {o_id, o_x, o_y, o_scale};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        i_in_valid = 1'b1;
        i_in_data  = b;
        while (!o_in_ready && g < 2000) begin
            tick();
            g++;
        end
        if (g >= 2000) check("in_ready_timeout", 64'(o_in_ready), 64'd1);
        tick();
        i_in_valid = 1'b0;
    endtask

    // Expected entry goes in first: the consumer may see the head right after the last byte.
    task automatic send_record(input sprite_entry_t e);
        logic [47:0] b = e;
        exp_q.push_back(e);
        for (int k = 0; k < 6; k++) send_byte(b[47-8*k -: 8]);
    endtask

    task automatic pop_check(input string name);
        sprite_entry_t e;
        if (exp_q.size() == 0) begin
            check({name, "_underflow"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(head()), 64'(e));
        end
        i_dequeue = 1'b1;
        tick();
        i_dequeue = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_empty"}, 64'(o_is_empty), 64'd1);
        check({name, "_ready"}, 64'(o_in_ready), 64'd1);
        check({name, "_count"}, 64'(o_count), 64'd0);
    endtask

    initial begin
        vec_t vecs[4];
        sprite_entry_t e;
        logic [47:0] bb;

        vecs[0] = '{48'h07012C00C840, 8'h07, 16'd300,   16'd200,   8'd64};
        vecs[1] = '{48'hFFFFFFFFFFFF, 8'hFF, 16'hFFFF,  16'hFFFF,  8'hFF};
        vecs[2] = '{48'h000000000000, 8'h00, 16'h0000,  16'h0000,  8'h00};
        vecs[3] = '{48'hA5123456789A, 8'hA5, 16'h1234,  16'h5678,  8'h9A};

        tick();
        tick();
        i_reset = 1'b0;
        check_reset_state("reset");

        // Single records from the table: decode, then one pop empties the queue.
        foreach (vecs[v]) begin
            bb = vecs[v].bytes;
            for (int k = 0; k < 6; k++) send_byte(bb[47-8*k -: 8]);
            check($sformatf("vec%0d_nonempty", v), 64'(o_is_empty), 64'd0);
            check($sformatf("vec%0d_fields", v), 64'(head()),
                  64'({vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].scale}));
            i_dequeue = 1'b1;
            tick();
            i_dequeue = 1'b0;
            check($sformatf("vec%0d_empty_after_pop", v), 64'(o_is_empty), 64'd1);
        end

        // Fill to capacity, stall the sixth byte of a 17th record, then drain.
        for (int i = 0; i < 16; i++) send_record('{8'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'(2*i)});
        check("fill_count", 64'(o_count), 64'd16);
        check("fill_ready_mid_record", 64'(o_in_ready), 64'd1);
        e = '{8'h11, 16'hBEEF, 16'hCAFE, 8'h33};
        bb = e;
        for (int k = 0; k < 5; k++) send_byte(bb[47-8*k -: 8]);
        check("full_ready_low", 64'(o_in_ready), 64'd0);
        i_in_valid = 1'b1;
        i_in_data  = bb[7:0];
        for (int k = 0; k < 3; k++) tick();
        i_in_valid = 1'b0;
        check("full_count_held", 64'(o_count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("drain%0d", i));
            tick();
        end
        check("drain_empty", 64'(o_is_empty), 64'd1);
        exp_q.push_back(e);
        send_byte(bb[7:0]);
        check("stalled_rec_count", 64'(o_count), 64'd1);
        pop_check("stalled_rec");

        // Final byte and dequeue in the same cycle with three records queued.
        for (int i = 0; i < 3; i++) send_record('{8'(20 + i), 16'(i), 16'(i), 8'(i)});
        e = '{8'd23, 16'h0303, 16'h0404, 8'h05};
        bb = e;
        for (int k = 0; k < 5; k++) send_byte(bb[47-8*k -: 8]);
        check("simul_pre_count", 64'(o_count), 64'd3);
        exp_q.push_back(e);
        i_in_valid = 1'b1;
        i_in_data  = bb[7:0];
        pop_check("simul_head20");
        i_in_valid = 1'b0;
        check("simul_count", 64'(o_count), 64'd3);
        check("simul_new_head", 64'(o_id), 64'd21);
        for (int i = 0; i < 3; i++) pop_check($sformatf("simul_drain%0d", i));
        check("simul_empty", 64'(o_is_empty), 64'd1);

        // Dequeue while empty, including alongside a completing push.
        i_dequeue = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        i_dequeue = 1'b0;
        check("empty_pop_count", 64'(o_count), 64'd0);
        e = '{8'h42, 16'h1111, 16'h2222, 8'h44};
        bb = e;
        for (int k = 0; k < 5; k++) send_byte(bb[47-8*k -: 8]);
        exp_q.push_back(e);
        i_dequeue = 1'b1;
        send_byte(bb[7:0]);
        i_dequeue = 1'b0;
        check("push_pop_empty_count", 64'(o_count), 64'd1);
        pop_check("no_skew_head");
        check("no_skew_empty", 64'(o_is_empty), 64'd1);

        // Flush drops queued records, the partial record and the concurrent byte.
        for (int i = 0; i < 5; i++) send_record('{8'(40 + i), 16'(i), 16'(i), 8'(i)});
        send_byte(8'h99);
        send_byte(8'h98);
        send_byte(8'h97);
        i_flush    = 1'b1;
        i_in_valid = 1'b1;
        i_in_data  = 8'h96;
        tick();
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        exp_q.delete();
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_empty", 64'(o_is_empty), 64'd1);
        send_record('{8'h5A, 16'h0A0B, 16'h0C0D, 8'h0E});
        check("post_flush_count", 64'(o_count), 64'd1);
        pop_check("post_flush_rec");

        // Synchronous reset in the middle of a record.
        send_byte(8'hEE);
        send_byte(8'hDD);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("mid_reset");
        send_record('{8'h63, 16'h4321, 16'h8765, 8'h21});
        pop_check("post_reset_rec");

        // Random records against a dequeue-then-recheck consumer.
        fork
            begin
                for (int r = 0; r < 100; r++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send_record(sprite_entry_t'({$urandom(), 16'($urandom())}));
                end
            end
            begin
                int got = 0;
                int guard = 0;
                while (got < 100 && guard < 30000) begin
                    if (!o_is_empty) begin
                        pop_check($sformatf("rand%0d", got));
                        tick();
                        got++;
                    end else begin
                        tick();
                    end
                    guard++;
                end
                check("rand_received", 64'(got), 64'd100);
            end
        join
        tick();
        check("rand_final_empty", 64'(o_is_empty), 64'd1);
        check("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
